// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: single entry, 1-cycle latency, valid/ready handshake with
// load-use bubble insertion, redirect flush and writeback snoop of held operands.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   id_reg_a,
    input  logic [XLEN-1:0]   id_reg_b,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              wb_load,
    input  logic [4:0]        wb_dest,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_is_load,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_reg_a,
    output logic [XLEN-1:0]   ex_reg_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic              lu_bubble,
    output logic [31:0]       lu_bubble_cnt
);

    logic              ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,      ex_pc_d;
    logic [4:0]        ex_rs1_q,     ex_rs1_d;
    logic [4:0]        ex_rs2_q,     ex_rs2_d;
    logic [4:0]        ex_rd_q,      ex_rd_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic [XLEN-1:0]   ex_reg_a_q,   ex_reg_a_d;
    logic [XLEN-1:0]   ex_reg_b_q,   ex_reg_b_d;
    logic [XLEN-1:0]   ex_imm_q,     ex_imm_d;
    logic [31:0]       lu_bubble_cnt_q, lu_bubble_cnt_d;

    logic advance;
    logic hazard;
    logic capture;

    always_comb begin
        advance   = !ex_valid_q || ex_ready;
        hazard    = ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) && id_valid &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd_q)) || (id_uses_rs2 && (id_rs2 == ex_rd_q)));
        id_ready  = advance && !hazard && !flush;
        capture   = id_valid && id_ready;
        lu_bubble = hazard && ex_ready && !flush;
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_is_load_d = ex_is_load_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_reg_a_d   = ex_reg_a_q;
        ex_reg_b_d   = ex_reg_b_q;
        ex_imm_d     = ex_imm_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture) begin
            ex_valid_d   = 1'b1;
            ex_pc_d      = id_pc;
            ex_rs1_d     = id_rs1;
            ex_rs2_d     = id_rs2;
            ex_rd_d      = id_rd;
            ex_is_load_d = id_is_load;
            ex_ctrl_d    = id_ctrl;
            ex_reg_a_d   = id_reg_a;
            ex_reg_b_d   = id_reg_b;
            ex_imm_d     = id_imm;
        end else if (advance) begin
            ex_valid_d = 1'b0;
        end else if (wb_load && (wb_dest != 5'd0)) begin
            // Held entry stalled by EX: keep operands current with retiring writes.
            if (wb_dest == ex_rs1_q) ex_reg_a_d = wb_data;
            if (wb_dest == ex_rs2_q) ex_reg_b_d = wb_data;
        end

        lu_bubble_cnt_d = lu_bubble_cnt_q;
        if (lu_bubble && (lu_bubble_cnt_q != 32'hFFFF_FFFF)) lu_bubble_cnt_d = lu_bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_is_load_q    <= 1'b0;
            ex_ctrl_q       <= '0;
            ex_reg_a_q      <= '0;
            ex_reg_b_q      <= '0;
            ex_imm_q        <= '0;
            lu_bubble_cnt_q <= '0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_is_load_q    <= ex_is_load_d;
            ex_ctrl_q       <= ex_ctrl_d;
            ex_reg_a_q      <= ex_reg_a_d;
            ex_reg_b_q      <= ex_reg_b_d;
            ex_imm_q        <= ex_imm_d;
            lu_bubble_cnt_q <= lu_bubble_cnt_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_is_load    = ex_is_load_q;
    assign ex_ctrl       = ex_ctrl_q;
    assign ex_reg_a      = ex_reg_a_q;
    assign ex_reg_b      = ex_reg_b_q;
    assign ex_imm        = ex_imm_q;
    assign lu_bubble_cnt = lu_bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the pipeline register.
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    logic              clk, rst, flush, id_valid, id_ready;
    logic [XLEN-1:0]   id_pc, id_reg_a, id_reg_b, id_imm, wb_data;
    logic [4:0]        id_rs1, id_rs2, id_rd, wb_dest;
    logic              id_uses_rs1, id_uses_rs2, id_is_load, wb_load;
    logic [CTRL_W-1:0] id_ctrl;
    logic              ex_valid, ex_ready, ex_is_load, lu_bubble;
    logic [XLEN-1:0]   ex_pc, ex_reg_a, ex_reg_b, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       lu_bubble_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              vld;
        logic [XLEN-1:0]   pc;
        logic [4:0]        rs1, rs2, rd;
        logic              ld;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   a, b, imm;
        longint            cnt;
    } model_t;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_is_load(id_is_load),
        .id_ctrl(id_ctrl), .id_reg_a(id_reg_a), .id_reg_b(id_reg_b), .id_imm(id_imm),
        .wb_load(wb_load), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_ctrl(ex_ctrl), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b), .ex_imm(ex_imm),
        .lu_bubble(lu_bubble), .lu_bubble_cnt(lu_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        wb_load = 1'b0; wb_dest = 5'd0; wb_data = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_load = 1'b0;
        id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_ctrl = '0; id_reg_a = '0; id_reg_b = '0; id_imm = '0;
    endtask

    task automatic present(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2, input logic ld);
        id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_load = ld;
        id_ctrl = CTRL_W'($urandom); id_reg_a = XLEN'($urandom);
        id_reg_b = XLEN'($urandom); id_imm = XLEN'($urandom);
    endtask

    task automatic test_reset;
        idle;
        rst = 1'b1;
        present(32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
        step; step;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        checks++;
        if ({ex_pc, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_ctrl, ex_reg_a, ex_reg_b, ex_imm} !== '0) begin
            errors++; $display("FAIL reset_fields ex_pc=%h ex_rd=%0d ex_reg_a=%h want all zero", ex_pc, ex_rd, ex_reg_a);
        end
        checks++; if (lu_bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", lu_bubble_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got %b want 1", id_ready); end
        idle; step; step;
    endtask

    task automatic test_streaming;
        logic [XLEN-1:0] pc;
        idle;
        for (int i = 0; i < 3; i++) begin
            pc = 32'h100 + 32'(4 * i);
            present(pc, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0);
            #1;
            checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, id_ready); end
            step;
            checks++;
            if (ex_valid !== 1'b1 || ex_pc !== pc) begin
                errors++; $display("FAIL stream_pc[%0d] got vld=%b pc=%h want vld=1 pc=%h", i, ex_valid, ex_pc, pc);
            end
        end
        idle; step;
    endtask

    task automatic test_load_use;
        logic [31:0] cnt0;
        idle;
        // lw x5 followed by a consumer of x5
        present(32'h200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        step;
        cnt0 = lu_bubble_cnt;
        present(32'h204, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (id_ready !== 1'b0 || lu_bubble !== 1'b1) begin
            errors++; $display("FAIL lu_bubble_cycle got ready=%b bubble=%b want ready=0 bubble=1", id_ready, lu_bubble);
        end
        step;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_after_bubble_valid got %b want 0", ex_valid); end
        checks++; if (lu_bubble_cnt !== cnt0 + 32'd1) begin errors++; $display("FAIL lu_cnt got %h want %h", lu_bubble_cnt, cnt0 + 32'd1); end
        step;
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin
            errors++; $display("FAIL lu_capture got vld=%b pc=%h want vld=1 pc=204", ex_valid, ex_pc);
        end
        // load to x0 never stalls
        present(32'h300, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        step;
        cnt0 = lu_bubble_cnt;
        present(32'h304, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (id_ready !== 1'b1 || lu_bubble !== 1'b0) begin
            errors++; $display("FAIL lu_rd0 got ready=%b bubble=%b want ready=1 bubble=0", id_ready, lu_bubble);
        end
        step;
        checks++;
        if (ex_pc !== 32'h304 || lu_bubble_cnt !== cnt0) begin
            errors++; $display("FAIL lu_rd0_capture got pc=%h cnt=%h want pc=304 cnt=%h", ex_pc, lu_bubble_cnt, cnt0);
        end
        idle; step;
    endtask

    task automatic test_snoop;
        idle;
        present(32'h400, 5'd3, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0);
        step;
        ex_ready = 1'b0;
        present(32'h404, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0);
        wb_load = 1'b1; wb_dest = 5'd3; wb_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL snoop_ready_a got %b want 0", id_ready); end
        step;
        wb_load = 1'b0;
        checks++;
        if (ex_reg_a !== 32'hDEAD_BEEF || ex_reg_b !== 32'hDEAD_BEEF || ex_pc !== 32'h400) begin
            errors++; $display("FAIL snoop_update got a=%h b=%h pc=%h want a=b=deadbeef pc=400", ex_reg_a, ex_reg_b, ex_pc);
        end
        wb_load = 1'b1; wb_dest = 5'd0; wb_data = 32'h1234_5678;
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL snoop_ready_b got %b want 0", id_ready); end
        step;
        checks++;
        if (ex_reg_a !== 32'hDEAD_BEEF || ex_reg_b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL snoop_x0 got a=%h b=%h want deadbeef", ex_reg_a, ex_reg_b);
        end
        idle; step; step;
    endtask

    task automatic test_flush;
        logic [31:0] cnt0;
        idle;
        present(32'h500, 5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
        step;
        cnt0 = lu_bubble_cnt;
        present(32'h504, 5'd7, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0 || lu_bubble !== 1'b0) begin
            errors++; $display("FAIL flush_comb got ready=%b bubble=%b want 0 0", id_ready, lu_bubble);
        end
        step;
        flush = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || lu_bubble_cnt !== cnt0) begin
            errors++; $display("FAIL flush_state got vld=%b cnt=%h want vld=0 cnt=%h", ex_valid, lu_bubble_cnt, cnt0);
        end
        idle; step;
    endtask

    task automatic test_saturation;
        idle;
        step;
        dut.lu_bubble_cnt_q = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            present(32'h600 + 32'(8 * i), 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
            step;
            present(32'h604 + 32'(8 * i), 5'd0, 5'd9, 5'd4, 1'b0, 1'b1, 1'b0);
            #1;
            checks++; if (lu_bubble !== 1'b1) begin errors++; $display("FAIL sat_bubble[%0d] got %b want 1", i, lu_bubble); end
            step;
            checks++;
            if (lu_bubble_cnt !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL sat_cnt[%0d] got %h want ffffffff", i, lu_bubble_cnt);
            end
            step;
        end
        idle; step;
    endtask

    task automatic test_random;
        model_t m;
        logic adv, hz, exp_rdy, exp_bub;
        idle;
        rst = 1'b1; step; rst = 1'b0;
        m = '{vld: 1'b0, pc: '0, rs1: '0, rs2: '0, rd: '0, ld: 1'b0, ctrl: '0, a: '0, b: '0, imm: '0, cnt: 0};
        for (int n = 0; n < 400; n++) begin
            flush    = ($urandom_range(9) == 0);
            ex_ready = ($urandom_range(9) < 7);
            wb_load  = 1'($urandom_range(1));
            wb_dest  = 5'($urandom_range(3));
            wb_data  = XLEN'($urandom);
            if ($urandom_range(3) != 0)
                present(XLEN'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                        1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            else
                id_valid = 1'b0;
            #1;
            adv     = !m.vld || ex_ready;
            hz      = m.vld && m.ld && (m.rd != 5'd0) && id_valid &&
                      ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
            exp_rdy = adv && !hz && !flush;
            exp_bub = hz && ex_ready && !flush;
            checks++; if (id_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, id_ready, exp_rdy); end
            checks++; if (lu_bubble !== exp_bub) begin errors++; $display("FAIL rnd_bubble[%0d] got %b want %b", n, lu_bubble, exp_bub); end
            if (exp_bub && m.cnt < 64'hFFFF_FFFF) m.cnt++;
            if (flush) m.vld = 1'b0;
            else if (id_valid && exp_rdy) begin
                m.vld = 1'b1; m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
                m.ld = id_is_load; m.ctrl = id_ctrl; m.a = id_reg_a; m.b = id_reg_b; m.imm = id_imm;
            end else if (adv) m.vld = 1'b0;
            else if (wb_load && wb_dest != 5'd0) begin
                if (wb_dest == m.rs1) m.a = wb_data;
                if (wb_dest == m.rs2) m.b = wb_data;
            end
            step;
            checks++; if (ex_valid !== m.vld) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, ex_valid, m.vld); end
            if (m.vld) begin
                checks++;
                if ({ex_pc, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_ctrl, ex_reg_a, ex_reg_b, ex_imm} !==
                    {m.pc, m.rs1, m.rs2, m.rd, m.ld, m.ctrl, m.a, m.b, m.imm}) begin
                    errors++;
                    $display("FAIL rnd_entry[%0d] got pc=%h rd=%0d a=%h b=%h want pc=%h rd=%0d a=%h b=%h",
                             n, ex_pc, ex_rd, ex_reg_a, ex_reg_b, m.pc, m.rd, m.a, m.b);
                end
            end
            checks++;
            if (lu_bubble_cnt !== 32'(m.cnt)) begin
                errors++; $display("FAIL rnd_cnt[%0d] got %h want %h", n, lu_bubble_cnt, 32'(m.cnt));
            end
        end
        idle; step;
    endtask

    initial begin
        rst = 1'b1;
        idle;
        test_reset;
        test_streaming;
        test_load_use;
        test_snoop;
        test_flush;
        test_saturation;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
